// File: rtl/pll_lock_supervisor.sv
// Lock supervisor and staged reset generator for the EF2 PLL wrapper.
// Optional lock-loss glitch filter: define PLL_SUP_GLITCH_FILTER_EN.
module pll_lock_supervisor #(
   parameter int unsigned NUM_CH             = 3,
   parameter int unsigned PLL_RST_CYC        = 32,
   parameter int unsigned RELOCK_TIMEOUT_CYC = 65536,
   parameter int unsigned LOCK_STABLE_CYC    = 1024,
   parameter int unsigned STAGE_GAP_CYC      = 16,
   parameter int unsigned MAX_RETRY          = 3
) (
   input  logic              refclk,
   input  logic              reset,
   input  logic              extlock,
   input  logic [NUM_CH-1:0] ch_mask,
   input  logic              clear_fault,
   output logic              pll_reset,
   output logic [NUM_CH-1:0] ch_rst,
   output logic              locked,
   output logic              fault,
   output logic [3:0]        retry_cnt,
   output logic [7:0]        loss_cnt
);

   localparam int unsigned CNT_MAX = 131072;

   if (NUM_CH < 1 || NUM_CH > 8 || PLL_RST_CYC < 2 || PLL_RST_CYC > CNT_MAX ||
       RELOCK_TIMEOUT_CYC < 1 || RELOCK_TIMEOUT_CYC > CNT_MAX ||
       LOCK_STABLE_CYC < 1 || LOCK_STABLE_CYC > CNT_MAX ||
       STAGE_GAP_CYC < 1 || (NUM_CH - 1) * STAGE_GAP_CYC >= CNT_MAX ||
       MAX_RETRY < 1 || MAX_RETRY > 15) begin : g_param_err
      $error("pll_lock_supervisor: parameter out of range");
   end

   localparam logic [2:0] S_PLL_RST   = 3'd0;
   localparam logic [2:0] S_WAIT_LOCK = 3'd1;
   localparam logic [2:0] S_STABLE    = 3'd2;
   localparam logic [2:0] S_RELEASE   = 3'd3;
   localparam logic [2:0] S_RUN       = 3'd4;
   localparam logic [2:0] S_FAULT     = 3'd5;

   localparam logic [16:0] PLL_LAST = 17'(PLL_RST_CYC - 1);
   localparam logic [16:0] TMO_LAST = 17'(RELOCK_TIMEOUT_CYC - 1);
   localparam logic [16:0] STB_LAST = 17'(LOCK_STABLE_CYC - 1);
   localparam logic [16:0] REL_LAST = 17'((NUM_CH - 1) * STAGE_GAP_CYC);

   logic [1:0]        ext_sync_q;
   logic              extlock_s;
   logic              qual_q;
   logic [2:0]        state_q, state_d;
   logic [16:0]       cnt_q, cnt_d;
   logic [3:0]        retry_q, retry_d;
   logic [7:0]        loss_q, loss_d;
   logic              pll_reset_q, pll_reset_d;
   logic [NUM_CH-1:0] ch_rst_q, ch_rst_d;
   logic              locked_q, locked_d;
   logic              fault_q, fault_d;

   assign extlock_s = ext_sync_q[1];

   always_ff @(posedge refclk) begin
      if (reset) ext_sync_q <= '0;
      else       ext_sync_q <= {ext_sync_q[0], extlock};
   end

`ifdef PLL_SUP_GLITCH_FILTER_EN
   // Loss qualifies on the 4th consecutive low cycle of extlock_s.
   logic [1:0] low_cnt_q;
   always_ff @(posedge refclk) begin
      if (reset || extlock_s) begin
         low_cnt_q <= '0;
         qual_q    <= 1'b0;
      end else begin
         if (low_cnt_q != 2'd3) low_cnt_q <= low_cnt_q + 2'd1;
         qual_q <= (low_cnt_q == 2'd3);
      end
   end
`else
   always_ff @(posedge refclk) begin
      if (reset) qual_q <= 1'b0;
      else       qual_q <= ~extlock_s;
   end
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 17'd1;
      retry_d = retry_q;
      loss_d  = loss_q;
      case (state_q)
         S_PLL_RST:   if (cnt_q == PLL_LAST) state_d = S_WAIT_LOCK;
         S_WAIT_LOCK: begin
            if (extlock_s) begin
               state_d = S_STABLE;
            end else if (cnt_q == TMO_LAST) begin
               retry_d = retry_q + 4'd1;
               state_d = (retry_d == 4'(MAX_RETRY)) ? S_FAULT : S_PLL_RST;
            end
         end
         S_STABLE: begin
            if (!extlock_s)              state_d = S_WAIT_LOCK;
            else if (cnt_q == STB_LAST)  state_d = S_RELEASE;
         end
         S_RELEASE, S_RUN: begin
            if (state_q == S_RUN) cnt_d = cnt_q;
            if (qual_q) begin
               state_d = S_PLL_RST;
               if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
            end else if (state_q == S_RELEASE && cnt_q == REL_LAST) begin
               state_d = S_RUN;
            end
         end
         S_FAULT: begin
            cnt_d = cnt_q;
            if (clear_fault) begin
               state_d = S_PLL_RST;
               retry_d = '0;
            end
         end
         default: state_d = S_PLL_RST;
      endcase

      if (state_d != state_q) cnt_d = '0;
      if (state_d == S_RUN && state_q != S_RUN) retry_d = '0;

      // Outputs are registered from the next state so they track it exactly.
      pll_reset_d = (state_d == S_PLL_RST) || (state_d == S_FAULT);
      locked_d    = (state_d == S_RUN);
      fault_d     = (state_d == S_FAULT);
      ch_rst_d    = '1;
      if (state_d == S_RUN) begin
         ch_rst_d = ch_mask;
      end else if (state_d == S_RELEASE) begin
         for (int unsigned k = 0; k < NUM_CH; k++)
            ch_rst_d[k] = ch_mask[k] | (32'(cnt_d) < k * STAGE_GAP_CYC);
      end
   end

   always_ff @(posedge refclk) begin
      if (reset) begin
         state_q     <= S_PLL_RST;
         cnt_q       <= '0;
         retry_q     <= '0;
         loss_q      <= '0;
         pll_reset_q <= 1'b1;
         ch_rst_q    <= '1;
         locked_q    <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         loss_q      <= loss_d;
         pll_reset_q <= pll_reset_d;
         ch_rst_q    <= ch_rst_d;
         locked_q    <= locked_d;
         fault_q     <= fault_d;
      end
   end

   assign pll_reset = pll_reset_q;
   assign ch_rst    = ch_rst_q;
   assign locked    = locked_q;
   assign fault     = fault_q;
   assign retry_cnt = retry_q;
   assign loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor (default parameters, short relock timeout).
module tb_pll_lock_supervisor;

   logic       refclk = 1'b0;
   logic       reset;
   logic       extlock;
   logic [2:0] ch_mask;
   logic       clear_fault;
   logic       pll_reset;
   logic [2:0] ch_rst;
   logic       locked;
   logic       fault;
   logic [3:0] retry_cnt;
   logic [7:0] loss_cnt;

   int checks = 0;
   int errors = 0;
   logic saw_locked;

   pll_lock_supervisor #(
      .NUM_CH(3),
      .RELOCK_TIMEOUT_CYC(100)
   ) dut (
      .refclk(refclk),
      .reset(reset),
      .extlock(extlock),
      .ch_mask(ch_mask),
      .clear_fault(clear_fault),
      .pll_reset(pll_reset),
      .ch_rst(ch_rst),
      .locked(locked),
      .fault(fault),
      .retry_cnt(retry_cnt),
      .loss_cnt(loss_cnt)
   );

   always #5 refclk = ~refclk;

   // Each call passes n rising edges; sampling happens on the falling edge.
   task automatic step(input int n);
      repeat (n) @(negedge refclk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, ".pll_reset"}, 32'(pll_reset), 32'd1);
      check({tag, ".ch_rst"},    32'(ch_rst),    32'h7);
      check({tag, ".locked"},    32'(locked),    32'd0);
      check({tag, ".fault"},     32'(fault),     32'd0);
      check({tag, ".retry"},     32'(retry_cnt), 32'd0);
      check({tag, ".loss"},      32'(loss_cnt),  32'd0);
   endtask

   initial begin
      reset = 1'b1; extlock = 1'b1; ch_mask = 3'b000; clear_fault = 1'b0;
      step(3);
      check_reset_vals("rst0");

      // Full bring-up with extlock high throughout.
      reset = 1'b0;
      step(31);  check("pllrst_hold31", 32'(pll_reset), 32'd1);
      step(1);   check("pllrst_fall32", 32'(pll_reset), 32'd0);
      step(1024); check("ch_at1056", 32'(ch_rst), 32'h7);
      step(1);   check("ch0_at1057", 32'(ch_rst), 32'h6);
                 check("lock_at1057", 32'(locked), 32'd0);
      step(16);  check("ch1_at1073", 32'(ch_rst), 32'h4);
      step(16);  check("ch2_at1089", 32'(ch_rst), 32'h0);
                 check("lock_at1089", 32'(locked), 32'd0);
      step(1);   check("lock_at1090", 32'(locked), 32'd1);
                 check("retry_run", 32'(retry_cnt), 32'd0);

      // Lock drops in RUN.
`ifdef PLL_SUP_GLITCH_FILTER_EN
      extlock = 1'b0; step(1); extlock = 1'b1;
      step(6);
      check("glitch_ch", 32'(ch_rst), 32'h0);
      check("glitch_lock", 32'(locked), 32'd1);
      check("glitch_loss", 32'(loss_cnt), 32'd0);
      extlock = 1'b0; step(5); extlock = 1'b1;
      step(1);   check("drop5_pre", 32'(ch_rst), 32'h0);
      step(1);   check("drop5_ch", 32'(ch_rst), 32'h7);
`else
      extlock = 1'b0; step(1); extlock = 1'b1;
      step(2);   check("drop1_pre", 32'(ch_rst), 32'h0);
                 check("drop1_prelock", 32'(locked), 32'd1);
      step(1);   check("drop1_ch", 32'(ch_rst), 32'h7);
`endif
      check("loss_lock", 32'(locked), 32'd0);
      check("loss_cnt1", 32'(loss_cnt), 32'd1);
      check("loss_pllrst", 32'(pll_reset), 32'd1);
      step(1089); check("reseq_ch", 32'(ch_rst), 32'h0);
                  check("reseq_lock0", 32'(locked), 32'd0);
      step(1);    check("reseq_lock1", 32'(locked), 32'd1);

      // Second loss, then reset in the middle of STABLE.
      extlock = 1'b0; step(8); extlock = 1'b1;
      step(500);
      check("stable_loss2", 32'(loss_cnt), 32'd2);
      check("stable_pll", 32'(pll_reset), 32'd0);
      check("stable_ch", 32'(ch_rst), 32'h7);
      reset = 1'b1;
      step(1);
      check_reset_vals("rst_mid");

      // Masked channel 1 keeps its slot.
      ch_mask = 3'b010;
      step(1);
      reset = 1'b0;
      step(1057); check("mask_slot0", 32'(ch_rst), 32'h6);
      step(16);   check("mask_slot1", 32'(ch_rst), 32'h6);
      step(16);   check("mask_slot2", 32'(ch_rst), 32'h2);
      step(1);    check("mask_run_lock", 32'(locked), 32'd1);
                  check("mask_run_ch", 32'(ch_rst), 32'h2);
      ch_mask = 3'b000;
      step(1);    check("mask_clear", 32'(ch_rst), 32'h0);

      // Loss after slot 1 of RELEASE.
      reset = 1'b1; step(2); reset = 1'b0;
      step(1073); check("rel_slot1", 32'(ch_rst), 32'h4);
      extlock = 1'b0;
      step(7);
      check("rel_loss_ch", 32'(ch_rst), 32'h7);
      check("rel_loss_cnt", 32'(loss_cnt), 32'd1);
      saw_locked = locked;
      for (int i = 0; i < 20; i++) begin
         step(1);
         saw_locked = saw_locked | locked;
      end
      check("rel_no_lock", 32'(saw_locked), 32'd0);

      // Retry timeout to FAULT with extlock never rising.
      reset = 1'b1; step(2); reset = 1'b0;
      step(131); check("tmo_r0", 32'(retry_cnt), 32'd0);
                 check("tmo_pll0", 32'(pll_reset), 32'd0);
      step(1);   check("tmo_r1", 32'(retry_cnt), 32'd1);
                 check("tmo_pll1", 32'(pll_reset), 32'd1);
      step(18);
      clear_fault = 1'b1; step(1); clear_fault = 1'b0;
      step(112); check("tmo_r1_hold", 32'(retry_cnt), 32'd1);
      step(1);   check("tmo_r2", 32'(retry_cnt), 32'd2);
      step(131); check("tmo_nofault", 32'(fault), 32'd0);
      step(1);   check("fault_set", 32'(fault), 32'd1);
                 check("fault_pll", 32'(pll_reset), 32'd1);
                 check("fault_r3", 32'(retry_cnt), 32'd3);
                 check("fault_ch", 32'(ch_rst), 32'h7);
      step(20);  check("fault_hold", 32'(fault), 32'd1);
      clear_fault = 1'b1; step(1); clear_fault = 1'b0;
      check("clr_fault", 32'(fault), 32'd0);
      check("clr_retry", 32'(retry_cnt), 32'd0);
      check("clr_pll", 32'(pll_reset), 32'd1);
      step(31);  check("clr_pll31", 32'(pll_reset), 32'd1);
      step(1);   check("clr_pll32", 32'(pll_reset), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
